// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two data-memory masters, the arbiter and the data SRAM.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin with a bounded lock, same-cycle grant,
// fixed one-cycle read return steered back to the master that issued the read.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);
  localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic          lock_q, lock_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [1:0]    rd_pend_q, rd_pend_d;

  logic          hold0_s, hold1_s;
  logic [1:0]    gnt_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;

  // Grant decision: a live lock wins first, then a lone requester, then round-robin
  always_comb begin
    gnt_s   = 2'b00;
    hold0_s = (owner_q == OWN_M0) && lock_q && bus.m0_req &&
              ((cnt_q < MAX_LOCK_C) || !bus.m1_req);
    hold1_s = (owner_q == OWN_M1) && lock_q && bus.m1_req &&
              ((cnt_q < MAX_LOCK_C) || !bus.m0_req);
    if (hold0_s) begin
      gnt_s = 2'b01;
    end else if (hold1_s) begin
      gnt_s = 2'b10;
    end else if (bus.m0_req && bus.m1_req) begin
      gnt_s = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt_s = {bus.m1_req, bus.m0_req};
    end
  end

  // Steer the winner onto the memory port; idle port is driven to zero
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = {AW{1'b0}};
    mem_wdata_s = {DW{1'b0}};
    if (gnt_s[0]) begin
      mem_we_s    = bus.m0_we;
      mem_addr_s  = bus.m0_addr;
      mem_wdata_s = bus.m0_wdata;
    end else if (gnt_s[1]) begin
      mem_we_s    = bus.m1_we;
      mem_addr_s  = bus.m1_addr;
      mem_wdata_s = bus.m1_wdata;
    end else begin
      mem_we_s    = 1'b0;
      mem_addr_s  = {AW{1'b0}};
      mem_wdata_s = {DW{1'b0}};
    end
  end

  // Next ownership, lock count and read-pending state
  always_comb begin
    owner_d   = OWN_NONE;
    lock_d    = 1'b0;
    cnt_d     = 4'd0;
    last_d    = last_q;
    rd_pend_d = gnt_s & {~bus.m1_we, ~bus.m0_we};
    if (gnt_s != 2'b00) begin
      last_d  = gnt_s[1];
      owner_d = gnt_s[1] ? OWN_M1 : OWN_M0;
      lock_d  = gnt_s[1] ? bus.m1_lock : bus.m0_lock;
      // The count only grows while the same master keeps a lock it asked for
      if ((owner_d == owner_q) && lock_q) begin
        cnt_d = (cnt_q >= MAX_LOCK_C) ? MAX_LOCK_C : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end else begin
      owner_d = OWN_NONE;
      lock_d  = 1'b0;
      cnt_d   = 4'd0;
    end
  end

  // State registers; reset discards any read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_NONE;
      lock_q    <= 1'b0;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      rd_pend_q <= 2'b00;
    end else begin
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign bus.m0_gnt    = gnt_s[0];
  assign bus.m1_gnt    = gnt_s[1];
  assign bus.mem_en    = |gnt_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;

  assign bus.m0_rvalid = rd_pend_q[0];
  assign bus.m1_rvalid = rd_pend_q[1];
  assign bus.m0_rdata  = rd_pend_q[0] ? bus.mem_rdata : {DW{1'b0}};
  assign bus.m1_rdata  = rd_pend_q[1] ? bus.mem_rdata : {DW{1'b0}};
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver predicts each cycle's grant and read
// return from the arbitration rules; a negedge monitor pops and compares.
module tb_dmem_arbiter;
  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int MAX_LOCK = 4;

  typedef struct {
    int            cyc;
    int            w;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM with one-cycle read latency
  logic [DW-1:0] sram [0:255];
  logic [DW-1:0] sram_rdata_q;
  bit            sram_clr;
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 256; i++) sram[i] <= '0;
      sram_rdata_q <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            sram_rdata_q <= sram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = sram_rdata_q;

  // Reference model state: owner -1 means nobody, last winner starts as master 1
  int            m_owner, m_cnt, m_last;
  bit            m_lock;
  logic [DW-1:0] ref_mem [0:255];
  exp_t          exp_q[$];
  rd_t           rd0_q[$];
  rd_t           rd1_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1);
    bit r [2];
    r[0] = r0;
    r[1] = r1;
    if (m_owner >= 0 && m_lock && r[m_owner] && (m_cnt < MAX_LOCK || !r[1 - m_owner]))
      return m_owner;
    if (r0 && r1) return 1 - m_last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic step(input bit r0, input bit w0, input bit l0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit r1, input bit w1, input bit l1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      output int win);
    exp_t e;
    rd_t  rd;
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
    win     = pick(r0, r1);
    e.cyc   = cyc;
    e.w     = win;
    e.we    = (win == 1) ? w1 : (win == 0) ? w0 : 1'b0;
    e.addr  = (win == 1) ? a1 : (win == 0) ? a0 : '0;
    e.wdata = (win == 1) ? d1 : (win == 0) ? d0 : '0;
    exp_q.push_back(e);
    if (win >= 0) begin
      if (e.we) begin
        ref_mem[e.addr] = e.wdata;
      end else begin
        rd.due  = cyc + 1;
        rd.data = ref_mem[e.addr];
        if (win == 0) rd0_q.push_back(rd);
        else          rd1_q.push_back(rd);
      end
      if (win == m_owner && m_lock) m_cnt = (m_cnt + 1 > MAX_LOCK) ? MAX_LOCK : m_cnt + 1;
      else                          m_cnt = 1;
      m_owner = win;
      m_lock  = (win == 1) ? l1 : l0;
      m_last  = win;
    end else begin
      m_owner = -1;
      m_lock  = 1'b0;
      m_cnt   = 0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    int w;
    repeat (n) step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, w);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    rst_n = 1'b0;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    rd0_q.delete();
    rd1_q.delete();
    m_owner = -1; m_lock = 1'b0; m_cnt = 0; m_last = 1;
    repeat (n) begin
      e.cyc = cyc; e.w = -1; e.we = 1'b0; e.addr = '0; e.wdata = '0;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
  endtask

  task automatic rd_check(input int m, input logic rv, input logic [DW-1:0] rdat);
    rd_t r;
    bit  due;
    if (m == 0) due = (rd0_q.size() > 0) && (rd0_q[0].due == cyc);
    else        due = (rd1_q.size() > 0) && (rd1_q[0].due == cyc);
    if (due) begin
      if (m == 0) r = rd0_q.pop_front();
      else        r = rd1_q.pop_front();
      chk($sformatf("rvalid%0d", m), 64'(rv), 64'(1'b1));
      chk($sformatf("rdata%0d", m), 64'(rdat), 64'(r.data));
    end else begin
      chk($sformatf("rvalid%0d_idle", m), 64'(rv), 64'(1'b0));
      chk($sformatf("rdata%0d_idle", m), 64'(rdat), 64'(0));
    end
  endtask

  // Monitor: one expected record per cycle, compared at the falling edge
  exp_t mon_e;
  int   wait0 = 0;
  int   wait1 = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sync", 64'(cyc), 64'(mon_e.cyc));
      chk("gnt", 64'({bus.m1_gnt, bus.m0_gnt}), 64'({mon_e.w == 1, mon_e.w == 0}));
      chk("mem", 64'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
          64'({mon_e.w >= 0, mon_e.we, mon_e.addr, mon_e.wdata}));
      rd_check(0, bus.m0_rvalid, bus.m0_rdata);
      rd_check(1, bus.m1_rvalid, bus.m1_rdata);
      if (bus.m0_req && !bus.m0_gnt) begin
        wait0++;
        chk("starve0", 64'(wait0 <= MAX_LOCK), 64'(1'b1));
      end else begin
        wait0 = 0;
      end
      if (bus.m1_req && !bus.m1_gnt) begin
        wait1++;
        chk("starve1", 64'(wait1 <= MAX_LOCK), 64'(1'b1));
      end else begin
        wait1 = 0;
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  int            w, k;
  bit            done0, p0, p1, we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  initial begin
    sram_clr = 1'b1;
    rst_n    = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    @(posedge clk);
    #2;
    sram_clr = 1'b0;
    do_reset(2);

    // Preload 0x10, reset, then a lone m0 read
    step(1, 1, 0, 8'h10, 16'h1234, 0, 0, 0, '0, '0, w);
    idle(1);
    do_reset(2);
    step(1, 0, 0, 8'h10, '0, 0, 0, 0, '0, '0, w);
    idle(2);

    // Continuous contention without lock alternates M0, M1
    do_reset(1);
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 8'(i + 16), '0, 1, 0, 0, 8'(i + 24), '0, w);
    idle(2);

    // m1 locked write burst with m0 waiting from the second cycle
    k = 0;
    done0 = 1'b0;
    for (int t = 0; t < 24 && (k < 8 || !done0); t++) begin
      step((t >= 1) && !done0, 1, 0, 8'h30, 16'hAAAA,
           k < 8, 1, 1, 8'(8'h40 + k), 16'(16'h0100 + k), w);
      if (w == 0) done0 = 1'b1;
      if (w == 1) k++;
    end
    idle(1);

    // m1 locked with m0 idle: every cycle granted, count saturates
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, '0, '0, 1, 1, 1, 8'(8'h50 + i), 16'(16'h0200 + i), w);
    idle(1);

    // m0 write then m1 read of the same word
    step(1, 1, 0, 8'h20, 16'hBEEF, 0, 0, 0, '0, '0, w);
    step(0, 0, 0, '0, '0, 1, 0, 0, 8'h20, '0, w);
    idle(2);

    // Reset right after an m0 read grant, then first tie after reset
    step(1, 0, 0, 8'h20, '0, 0, 0, 0, '0, '0, w);
    do_reset(2);
    step(1, 0, 0, 8'h10, '0, 1, 0, 0, 8'h20, '0, w);
    step(0, 0, 0, '0, '0, 1, 0, 0, 8'h20, '0, w);
    idle(2);

    // Randomised traffic obeying the hold-until-grant rule
    p0 = 1'b0;
    p1 = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (n == 800) begin
        do_reset(1);
        p0 = 1'b0;
        p1 = 1'b0;
      end
      if (!p0 && $urandom_range(0, 99) < ((n < 700) ? 55 : 90)) begin
        p0 = 1'b1;
        we0 = 1'($urandom_range(0, 1));
        a0 = 8'($urandom_range(0, 31));
        d0 = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 99) < ((n < 700) ? 55 : 90)) begin
        p1 = 1'b1;
        we1 = 1'($urandom_range(0, 1));
        a1 = 8'($urandom_range(0, 31));
        d1 = 16'($urandom);
      end
      step(p0, we0, 1'($urandom_range(0, 1)), a0, d0,
           p1, we1, 1'($urandom_range(0, 1)), a1, d1, w);
      if (w == 0) p0 = 1'b0;
      if (w == 1) p1 = 1'b0;
    end

    idle(3);
    chk("drain", 64'(exp_q.size() + rd0_q.size() + rd1_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
